// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared types, mode encodings and clamp limits for the stereo de-matrix
package stereo_pkg;

  typedef enum logic {S_FILL, S_PUSH} state_t;

  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;

  // Limits are returned 64 bits wide; callers size-cast to their sample width.
  function automatic logic [63:0] SAT_MAX(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] SAT_MIN(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/stereo_matrix_fifo.sv
// rtl/stereo_matrix_fifo.sv - first-word-fall-through FIFO used on both sides of the de-matrix
module stereo_matrix_fifo #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] din,
  input  logic                 wr_en,
  output logic                 full,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_wr, do_rd;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
      else if (do_rd && !do_wr) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/stereo_matrix_top.sv
// rtl/stereo_matrix_top.sv - FM stereo de-matrix: left = lpr + lmr, right = lpr - lmr
module stereo_matrix_top
  import stereo_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter bit SATURATE   = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] lpr_din,
  input  logic                 lpr_wr_en,
  output logic                 lpr_full,
  input  logic [DATA_SIZE-1:0] lmr_din,
  input  logic                 lmr_wr_en,
  output logic                 lmr_full,
  input  logic [1:0]           mode,
  input  logic                 left_rd_en,
  output logic [DATA_SIZE-1:0] left_dout,
  output logic                 left_empty,
  input  logic                 right_rd_en,
  output logic [DATA_SIZE-1:0] right_dout,
  output logic                 right_empty,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 sat_flag
);

  logic [DATA_SIZE-1:0] lpr_data, lmr_data;
  logic                 lpr_empty, lmr_empty, left_full, right_full;
  logic                 pop, push, out_ready;
  logic [DATA_SIZE:0]   sum_ext, dif_ext;
  logic                 sat_hit;

  state_t               state_q;
  logic [DATA_SIZE-1:0] left_q, right_q;
  logic                 left_en_q, right_en_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 sat_q;

  stereo_matrix_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_lpr_fifo (
    .clock(clock), .reset(reset), .din(lpr_din), .wr_en(lpr_wr_en), .full(lpr_full),
    .rd_en(pop), .dout(lpr_data), .empty(lpr_empty));

  stereo_matrix_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_lmr_fifo (
    .clock(clock), .reset(reset), .din(lmr_din), .wr_en(lmr_wr_en), .full(lmr_full),
    .rd_en(pop), .dout(lmr_data), .empty(lmr_empty));

  stereo_matrix_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_left_fifo (
    .clock(clock), .reset(reset), .din(left_q), .wr_en(push && left_en_q), .full(left_full),
    .rd_en(left_rd_en), .dout(left_dout), .empty(left_empty));

  stereo_matrix_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_right_fifo (
    .clock(clock), .reset(reset), .din(right_q), .wr_en(push && right_en_q), .full(right_full),
    .rd_en(right_rd_en), .dout(right_dout), .empty(right_empty));

  // A disabled output never blocks, so one-sided modes keep streaming.
  assign out_ready = (!left_en_q || !left_full) && (!right_en_q || !right_full);
  assign push      = (state_q == S_PUSH) && out_ready;
  assign pop       = !lpr_empty && !lmr_empty && ((state_q == S_FILL) || push);

  assign sum_ext = {lpr_data[DATA_SIZE-1], lpr_data} + {lmr_data[DATA_SIZE-1], lmr_data};
  assign dif_ext = {lpr_data[DATA_SIZE-1], lpr_data} - {lmr_data[DATA_SIZE-1], lmr_data};
  assign sat_hit = SATURATE && ((sum_ext[DATA_SIZE] ^ sum_ext[DATA_SIZE-1]) ||
                                (dif_ext[DATA_SIZE] ^ dif_ext[DATA_SIZE-1]));

  function automatic logic [DATA_SIZE-1:0] limit(input logic [DATA_SIZE:0] v);
    if (SATURATE && (v[DATA_SIZE] != v[DATA_SIZE-1]))
      return v[DATA_SIZE] ? DATA_SIZE'(SAT_MIN(DATA_SIZE)) : DATA_SIZE'(SAT_MAX(DATA_SIZE));
    return v[DATA_SIZE-1:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FILL;
      left_q     <= '0;
      right_q    <= '0;
      left_en_q  <= 1'b1;
      right_en_q <= 1'b1;
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      if (pop) begin
        left_q     <= limit(sum_ext);
        right_q    <= limit(dif_ext);
        left_en_q  <= (mode != MODE_RIGHT);
        right_en_q <= (mode != MODE_LEFT);
        count_q    <= count_q + 1'b1;
        if (sat_hit) sat_q <= 1'b1;
      end
      case (state_q)
        S_FILL:  if (pop) state_q <= S_PUSH;
        S_PUSH:  if (push && !pop) state_q <= S_FILL;
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign sample_count = count_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_stereo_matrix_top.sv
// tb/tb_stereo_matrix_top.sv - directed bench for stereo_matrix_top, saturating and wrapping builds
module tb_stereo_matrix_top;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] lpr_din = '0, lmr_din = '0;
  logic        lpr_wr_en = 1'b0, lmr_wr_en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        left_rd_en = 1'b0, right_rd_en = 1'b0;

  logic        s_lpr_full, s_lmr_full, s_left_empty, s_right_empty, s_sat_flag;
  logic [31:0] s_left_dout, s_right_dout;
  logic [15:0] s_sample_count;
  logic        w_lpr_full, w_lmr_full, w_left_empty, w_right_empty, w_sat_flag;
  logic [31:0] w_left_dout, w_right_dout;
  logic [15:0] w_sample_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  logic [31:0] nom_lpr [6] = '{32'd100, 32'hFFFFFFFB, 32'd0, 32'd1000, 32'h12345678, 32'hFFFFFF9C};
  logic [31:0] nom_lmr [6] = '{32'd20, 32'd3, 32'd0, 32'hFFFFFC18, 32'h01010101, 32'hFFFFFFCE};
  logic [31:0] nom_l   [6] = '{32'd120, 32'hFFFFFFFE, 32'd0, 32'd0, 32'h13355779, 32'hFFFFFF6A};
  logic [31:0] nom_r   [6] = '{32'd80, 32'hFFFFFFF8, 32'd0, 32'h000007D0, 32'h11335577, 32'hFFFFFFCE};

  always #5 clock = ~clock;

  stereo_matrix_top #(.DATA_SIZE(32), .FIFO_DEPTH(16), .SATURATE(1'b1), .CNT_WIDTH(16)) u_sat (
    .clock(clock), .reset(reset),
    .lpr_din(lpr_din), .lpr_wr_en(lpr_wr_en), .lpr_full(s_lpr_full),
    .lmr_din(lmr_din), .lmr_wr_en(lmr_wr_en), .lmr_full(s_lmr_full),
    .mode(mode),
    .left_rd_en(left_rd_en), .left_dout(s_left_dout), .left_empty(s_left_empty),
    .right_rd_en(right_rd_en), .right_dout(s_right_dout), .right_empty(s_right_empty),
    .sample_count(s_sample_count), .sat_flag(s_sat_flag));

  stereo_matrix_top #(.DATA_SIZE(32), .FIFO_DEPTH(16), .SATURATE(1'b0), .CNT_WIDTH(16)) u_wrap (
    .clock(clock), .reset(reset),
    .lpr_din(lpr_din), .lpr_wr_en(lpr_wr_en), .lpr_full(w_lpr_full),
    .lmr_din(lmr_din), .lmr_wr_en(lmr_wr_en), .lmr_full(w_lmr_full),
    .mode(mode),
    .left_rd_en(left_rd_en), .left_dout(w_left_dout), .left_empty(w_left_empty),
    .right_rd_en(right_rd_en), .right_dout(w_right_dout), .right_empty(w_right_empty),
    .sample_count(w_sample_count), .sat_flag(w_sat_flag));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input bit do_lpr, input bit do_lmr, input logic [31:0] a, input logic [31:0] b);
    lpr_din   = a;
    lmr_din   = b;
    lpr_wr_en = do_lpr;
    lmr_wr_en = do_lmr;
    idle(1);
    lpr_wr_en = 1'b0;
    lmr_wr_en = 1'b0;
  endtask

  task automatic pop(input bit do_l, input bit do_r, input logic [31:0] el, input logic [31:0] er,
                     input logic [31:0] wl, input logic [31:0] wr, input string tag);
    int t = 0;
    while (((do_l && (s_left_empty || w_left_empty)) || (do_r && (s_right_empty || w_right_empty))) && t < 50) begin
      idle(1);
      t++;
    end
    chk({tag, " wait"}, 64'(t < 50), 64'd1);
    if (do_l) begin
      chk({tag, " s_left"}, s_left_dout, el);
      chk({tag, " w_left"}, w_left_dout, wl);
    end
    if (do_r) begin
      chk({tag, " s_right"}, s_right_dout, er);
      chk({tag, " w_right"}, w_right_dout, wr);
    end
    left_rd_en  = do_l;
    right_rd_en = do_r;
    idle(1);
    left_rd_en  = 1'b0;
    right_rd_en = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " s_left_empty"}, s_left_empty, 1);
    chk({tag, " s_right_empty"}, s_right_empty, 1);
    chk({tag, " w_left_empty"}, w_left_empty, 1);
    chk({tag, " w_right_empty"}, w_right_empty, 1);
    chk({tag, " s_lpr_full"}, s_lpr_full, 0);
    chk({tag, " s_lmr_full"}, s_lmr_full, 0);
    chk({tag, " s_left_dout"}, s_left_dout, 0);
    chk({tag, " s_right_dout"}, s_right_dout, 0);
    chk({tag, " s_count"}, s_sample_count, 0);
    chk({tag, " w_count"}, w_sample_count, 0);
    chk({tag, " s_sat"}, s_sat_flag, 0);
    chk({tag, " w_sat"}, w_sat_flag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset_checks("por");
    reset = 1'b1;
    idle(1);

    for (int i = 0; i < 6; i++) push(1, 1, nom_lpr[i], nom_lmr[i]);
    for (int i = 0; i < 6; i++) pop(1, 1, nom_l[i], nom_r[i], nom_l[i], nom_r[i], "nom");
    chk("nom count", s_sample_count, 6);
    chk("nom sat", s_sat_flag, 0);

    push(1, 1, 32'h7FFFFFFF, 32'h00000001);
    push(1, 1, 32'h80000000, 32'h00000001);
    pop(1, 1, 32'h7FFFFFFF, 32'h7FFFFFFE, 32'h80000000, 32'h7FFFFFFE, "sat_pos");
    pop(1, 1, 32'h80000001, 32'h80000000, 32'h80000001, 32'h7FFFFFFF, "sat_neg");
    chk("sat s_flag", s_sat_flag, 1);
    chk("sat w_flag", w_sat_flag, 0);

    // Backpressure: no reads, overfill the inputs.
    for (int i = 0; i < 40; i++) begin
      if (!s_lpr_full && !s_lmr_full) begin
        push(1, 1, 32'(3 * i), 32'(i));
        n_acc++;
      end else begin
        idle(1);
      end
    end
    chk("bp accepted", 64'(n_acc), 33);
    chk("bp lpr_full", s_lpr_full, 1);
    chk("bp lmr_full", s_lmr_full, 1);
    chk("bp count", s_sample_count, 25);
    for (int i = 0; i < 16; i++) pop(1, 0, 32'(4 * i), 0, 32'(4 * i), 0, "bp left");
    idle(5);
    chk("bp left stalled", s_left_empty, 1);
    chk("bp lpr still full", s_lpr_full, 1);
    for (int i = 0; i < 16; i++) pop(0, 1, 0, 32'(2 * i), 0, 32'(2 * i), "bp right");
    for (int i = 16; i < 33; i++) pop(1, 1, 32'(4 * i), 32'(2 * i), 32'(4 * i), 32'(2 * i), "bp both");
    idle(5);
    chk("bp drained left", s_left_empty, 1);
    chk("bp drained right", s_right_empty, 1);
    chk("bp count end", s_sample_count, 41);

    mode = 2'b01;
    for (int k = 1; k <= 5; k++) push(1, 0, 32'(10 * k), 0);
    idle(5);
    chk("pair lpr only", s_left_empty, 1);
    chk("pair count hold", s_sample_count, 41);
    for (int k = 1; k <= 5; k++) push(0, 1, 0, 32'(k));
    for (int k = 1; k <= 5; k++) pop(1, 0, 32'(11 * k), 0, 32'(11 * k), 0, "pair");
    idle(5);
    chk("pair left done", s_left_empty, 1);
    chk("pair right idle", s_right_empty, 1);
    chk("pair count", s_sample_count, 46);

    mode = 2'b00;
    for (int i = 0; i < 3; i++) push(1, 1, 32'(50 + i), 32'(i));
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_checks("mid");
    reset = 1'b1;
    idle(1);
    push(1, 1, 32'd7, 32'd2);
    pop(1, 1, 32'd9, 32'd5, 32'd9, 32'd5, "post");
    idle(5);
    chk("post only new", s_left_empty, 1);
    chk("post count", s_sample_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
